// File: rtl/inst_fetch_seq.sv
// Instruction-fetch sequencer: drives inst_mem, registers word+PC for decode.
// Optional perf counters enabled by defining INST_FETCH_PERF_EN.
module inst_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        dec_ready
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] inst_n;
  logic [31:0] inst_pc_n;
  logic        valid_n;
  logic        capture;
  logic        accept;
  logic        slot_free;

  assign imem_addr = pc;
  assign accept    = inst_valid & dec_ready;
  assign slot_free = !inst_valid | dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    inst_n    = inst;
    inst_pc_n = inst_pc;
    valid_n   = inst_valid;
    capture   = 1'b0;
    if (redirect) begin
      // Flush wins over any handshake in the same cycle
      pc_n    = redirect_pc;
      valid_n = 1'b0;
      state_n = fetch_en ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          valid_n = 1'b0;
          if (fetch_en) state_n = RUN;
        end
        RUN: begin
          capture = slot_free & fetch_en;
          if (!capture && accept) valid_n = 1'b0;
          if (!fetch_en) begin
            state_n = DRAIN;
          end else if (inst_valid && !dec_ready) begin
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (dec_ready) begin
            state_n = RUN;
            capture = fetch_en;
            if (!fetch_en) valid_n = 1'b0;
          end
        end
        DRAIN: begin
          if (accept) valid_n = 1'b0;
          if (fetch_en) begin
            state_n = RUN;
          end else if (!inst_valid || accept) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
      if (capture) begin
        inst_n    = imem_data;
        inst_pc_n = pc;
        valid_n   = 1'b1;
        pc_n      = pc + PC_INC;
      end
    end
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (capture) fetch_count <= fetch_count + 32'd1;
      if (redirect && inst_valid) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Testbench for inst_fetch_seq: directed test-plan steps then random traffic
// checked every cycle against a two-flag behavioural model.
module tb_inst_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        dec_ready;
`ifdef INST_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int passed = 0;
  int total  = 0;

  logic [31:0] m_pc, m_inst, m_ipc;
  logic        m_valid;
  logic        m_fetching;
  logic        m_parked;
  logic [31:0] m_fc;
  logic [15:0] m_flc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h1111;
  endfunction

  assign imem_data = mem_word(imem_addr);

  inst_fetch_seq dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .dec_ready(dec_ready)
`ifdef INST_FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .flush_count(flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic compare_all();
    check("imem_addr", imem_addr, m_pc);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
    check("inst_pc", inst_pc, m_ipc);
    check("inst", inst, m_inst);
`ifdef INST_FETCH_PERF_EN
    check("fetch_count", fetch_count, m_fc);
    check("flush_count", {16'd0, flush_count}, {16'd0, m_flc});
`endif
  endtask

  task automatic model_reset();
    m_pc       = RST_PC;
    m_inst     = '0;
    m_ipc      = '0;
    m_valid    = 1'b0;
    m_fetching = 1'b0;
    m_parked   = 1'b0;
    m_fc       = '0;
    m_flc      = '0;
  endtask

  // One clock edge of reference behaviour: "fetching" covers active
  // fetching (including a stalled word), "parked" means decode stalled
  // us while fetching and we keep fetching rights until it drains.
  task automatic model_edge(input logic fe, input logic rd,
                            input logic [31:0] rpc, input logic dr);
    logic acc, free, was_valid;
    acc       = m_valid & dr;
    free      = !m_valid | dr;
    was_valid = m_valid;
    if (rd) begin
      if (m_valid) m_flc = m_flc + 16'd1;
      m_pc       = rpc;
      m_valid    = 1'b0;
      m_fetching = fe;
      m_parked   = 1'b0;
    end else if (m_fetching) begin
      if (fe && free) begin
        m_inst  = mem_word(m_pc);
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd1;
        m_fc    = m_fc + 32'd1;
      end else if (acc) begin
        m_valid = 1'b0;
      end
      if (m_parked) m_parked = !dr;
      else if (!fe) m_fetching = 1'b0;
      else m_parked = was_valid & !dr;
    end else begin
      if (acc) m_valid = 1'b0;
      m_fetching = fe;
    end
  endtask

  task automatic step(input logic fe, input logic rd,
                      input logic [31:0] rpc, input logic dr);
    rst         = 1'b0;
    fetch_en    = fe;
    redirect    = rd;
    redirect_pc = rpc;
    dec_ready   = dr;
    @(posedge clk);
    model_edge(fe, rd, rpc, dr);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input logic fe);
    rst         = 1'b1;
    fetch_en    = fe;
    redirect    = 1'b1;
    redirect_pc = 32'hDEAD_BEEF;
    dec_ready   = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
  endtask

  task automatic run_until_ipc(input string tag, input logic [31:0] target);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (m_valid && m_ipc == target) found = 1'b1;
      else step(1'b1, 1'b0, 32'd0, 1'b1);
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b0;
    model_reset();

    do_reset(1'b0);
    check("reset_addr", imem_addr, RST_PC);
    check("reset_valid", {31'd0, inst_valid}, 32'd0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    run_until_ipc("reach_pc2", 32'd2);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
    check("stall_addr", imem_addr, 32'd3);
    check("stall_ipc", inst_pc, 32'd2);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("release_ipc", inst_pc, 32'd3);

    run_until_ipc("reach_pc5", 32'd5);
    step(1'b1, 1'b1, 32'h40, 1'b1);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_valid", {31'd0, inst_valid}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_ipc", inst_pc, 32'h40);
`ifdef INST_FETCH_PERF_EN
    check("flush_one", {16'd0, flush_count}, 32'd1);
`endif

    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("hold_redir_ipc", inst_pc, 32'h100);
    step(1'b1, 1'b0, 32'd0, 1'b1);

    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("wrap_ipc", inst_pc, 32'd1);

    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    check("drain_held", {31'd0, inst_valid}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("drain_done", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    do_reset(1'b1);
    check("midrun_rst_addr", imem_addr, RST_PC);

    for (int i = 0; i < 3000; i++) begin
      logic        fe, rd, dr;
      logic [31:0] rpc;
      fe  = ($urandom % 8) != 0;
      dr  = ($urandom % 4) != 0;
      rd  = ($urandom % 16) == 0;
      rpc = (($urandom % 4) == 0) ? 32'hFFFF_FFFE + ($urandom % 2)
                                  : $urandom;
      if (($urandom % 200) == 0) do_reset(fe);
      else step(fe, rd, rpc, dr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
